game_ctrl: RTL and testbench
============================

# game_ctrl

Sequencing controller for the grid-runner player block. Converts debounced button levels into single-cycle, rate-limited, mutually exclusive move pulses. Drives the player's pause and respawn-reset inputs. Tracks lives, score and the top-level game state (title, play, pause, death, level-up, game over). Sits between the button debouncers and the player/collision logic, under the VGA top level.

## Interface
Parameters:
- MOVE_GAP, default 2: minimum cycles between two issued move pulses (≥1).
- DEATH_CYCLES, default 4: freeze length after a hit, in cycles (≥1).
- LEVEL_CYCLES, default 4: freeze length after a level change, in cycles (≥1).
- START_LIVES, default 3: lives loaded at game start (1..3).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- btn_up, btn_left, btn_right, btn_down  in  1 each  debounced, synchronous button levels.
- btn_start  in  1  debounced start button level.
- pause_sw  in  1  pause switch level.
- hit  in  1  collision flag from obstacle logic; sampled only in PLAY.
- level_in  in  10  level count reported by player block.
- mv_up, mv_left, mv_right, mv_down  out  1 each  one-cycle move pulses; at most one high per cycle.
- player_pause  out  1  freeze request to player.
- player_reset  out  1  one-cycle respawn pulse to player.
- lives  out  2  remaining lives.
- score  out  16  score.
- state  out  3  encoded FSM state.

## Operation
- Reset (rst_n=0, async): state=TITLE, mv_* = 0, player_pause=1, player_reset=0, lives=START_LIVES, score=0. Edge registers cleared. Cooldown=0. last_level=1.
- Edge detect: a direction request is latched on a rising edge of its btn_* (prev=0, now=1). Held buttons never repeat.
- Pending: one pending-request bit per direction, set by its edge.
  - All pending bits clear on any exit from PLAY.
  - Edges arriving outside PLAY are discarded.
- Arbitration (PLAY, cooldown=0, any pending): issue exactly one pulse. Fixed priority up > down > left > right. Clear that pending bit and load cooldown=MOVE_GAP-1.
  - Other pending bits stay and issue on later slots.
  - Cooldown decrements to 0, saturating.
- States (state encoding in parentheses):
  - TITLE (0): player_pause=1. A btn_start rising edge goes to PLAY, pulses player_reset, and loads lives=START_LIVES, score=0, last_level=level_in.
  - PLAY (1): player_pause=0. Transitions, in precedence order:
    - hit → DYING; lives decremented on the transition cycle.
    - level_in ≠ last_level → LEVELUP; last_level=level_in, score += 100 (saturate at 65535).
    - pause_sw → PAUSED.
  - PAUSED (2): player_pause=1. Returns to PLAY when pause_sw=0. hit ignored.
  - DYING (3): player_pause=1. Timer counts DEATH_CYCLES.
    - On expiry, if lives=0 → OVER.
    - Otherwise → PLAY with a player_reset pulse.
  - LEVELUP (4): player_pause=1. After LEVEL_CYCLES → PLAY. No reset pulse, because the player already wrapped h.
  - OVER (5): player_pause=1. A btn_start rising edge → TITLE. lives and score hold for display.
- Score also +1 per issued mv_right pulse (saturating).
- A btn_start edge is ignored in all states except TITLE and OVER.

## Timing
- Move latency: button rising edge at cycle N (sampled) → mv_* high at cycle N+1, provided cooldown=0 and no higher-priority request is pending.
- Pulse spacing: consecutive mv_* pulses are ≥MOVE_GAP cycles apart.
- player_reset: exactly one cycle, on the first cycle of PLAY after TITLE or DYING. player_pause=0 in that same cycle.
- PLAY→DYING/LEVELUP/PAUSED: player_pause rises in the cycle after the triggering input is sampled. No mv_* pulse is issued in that cycle or later until PLAY resumes.
- Simultaneous hit and level change: hit wins; last_level is still updated, but no score is added.
- lives decrement saturates at 0 (never wraps to 3).
- rst_n assertion mid-DYING/LEVELUP aborts timers immediately; no residual pulses after release.
- level_in compared as full 10 bits, so a wrap of level_in is still a change.

## Test plan
- Reset then btn_start edge: state 0→1, player_reset high exactly 1 cycle, lives=3, score=0, player_pause=0.
- In PLAY, MOVE_GAP=2: btn_up and btn_right rise in the same cycle → mv_up at N+1, mv_right at N+3, and never both high together. A held btn_up for 10 cycles → only one mv_up.
- 3 hits separated by DEATH_CYCLES, expected outcome for each:
  - Hit 1 → lives 2, player_reset pulse after 4 cycles.
  - Hit 2 → lives 1.
  - Hit 3 → lives 0, state=5, no reset pulse.
  - Then btn_start → state 0.
- level_in steps 1→2 in PLAY: state=4 for 4 cycles, player_pause=1, score increases by exactly 100. A button edge during LEVELUP produces no pulse.
- pause_sw=1 with a pending left: no mv_left while PAUSED and pending cleared. After pause_sw=0, a new edge is needed to move.
- rst_n low during DYING: all outputs immediately return to reset values; after release, state=0 with no player_reset pulse.

Source files
------------

// File: rtl/game_ctrl.sv
// game_ctrl: grid-runner sequencing controller.
// Turns button levels into rate-limited move pulses and runs the game FSM.
module game_ctrl #(
   parameter int MOVE_GAP     = 2,
   parameter int DEATH_CYCLES = 4,
   parameter int LEVEL_CYCLES = 4,
   parameter int START_LIVES  = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        btn_up,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_down,
   input  logic        btn_start,
   input  logic        pause_sw,
   input  logic        hit,
   input  logic [9:0]  level_in,
   output logic        mv_up,
   output logic        mv_left,
   output logic        mv_right,
   output logic        mv_down,
   output logic        player_pause,
   output logic        player_reset,
   output logic [1:0]  lives,
   output logic [15:0] score,
   output logic [2:0]  state
);

   localparam int TMAX = (DEATH_CYCLES > LEVEL_CYCLES) ?
                         DEATH_CYCLES : LEVEL_CYCLES;
   localparam int TW = $clog2(TMAX + 1);
   localparam int CW = $clog2(MOVE_GAP + 1);

   typedef enum logic [2:0] {
      ST_TITLE   = 3'd0,
      ST_PLAY    = 3'd1,
      ST_PAUSED  = 3'd2,
      ST_DYING   = 3'd3,
      ST_LEVELUP = 3'd4,
      ST_OVER    = 3'd5
   } state_e;

   // direction bit order: 0 up, 1 down, 2 left, 3 right (priority order)
   state_e        state_q, state_d;
   logic [3:0]    dir_prev_q, dir_prev_d;
   logic          start_prev_q, start_prev_d;
   logic [3:0]    pend_q, pend_d;
   logic [CW-1:0] cool_q, cool_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [1:0]    lives_q, lives_d;
   logic [15:0]   score_q, score_d;
   logic [9:0]    last_level_q, last_level_d;
   logic [3:0]    mv_q, mv_d;
   logic          preset_q, preset_d;

   logic [3:0]    dir_now;
   logic [3:0]    dir_edge;
   logic [3:0]    req;
   logic          start_edge;
   logic [16:0]   sum_lvl;
   logic [16:0]   sum_mv;

   // state register and all bookkeeping flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_TITLE;
         dir_prev_q   <= '0;
         start_prev_q <= 1'b0;
         pend_q       <= '0;
         cool_q       <= '0;
         timer_q      <= '0;
         lives_q      <= 2'(START_LIVES);
         score_q      <= '0;
         last_level_q <= 10'd1;
         mv_q         <= '0;
         preset_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         dir_prev_q   <= dir_prev_d;
         start_prev_q <= start_prev_d;
         pend_q       <= pend_d;
         cool_q       <= cool_d;
         timer_q      <= timer_d;
         lives_q      <= lives_d;
         score_q      <= score_d;
         last_level_q <= last_level_d;
         mv_q         <= mv_d;
         preset_q     <= preset_d;
      end
   end

   // next-state, arbitration, timers, lives and score
   always_comb begin
      dir_now      = {btn_right, btn_left, btn_down, btn_up};
      dir_edge     = dir_now & ~dir_prev_q;
      start_edge   = btn_start & ~start_prev_q;
      req          = pend_q | dir_edge;
      sum_lvl      = {1'b0, score_q} + 17'd100;
      sum_mv       = {1'b0, score_q} + 17'd1;
      state_d      = state_q;
      dir_prev_d   = dir_now;
      start_prev_d = btn_start;
      pend_d       = '0;
      cool_d       = (cool_q != '0) ? cool_q - CW'(1) : cool_q;
      timer_d      = timer_q;
      lives_d      = lives_q;
      score_d      = score_q;
      last_level_d = last_level_q;
      mv_d         = '0;
      preset_d     = 1'b0;
      case (state_q)
         ST_TITLE: begin
            if (start_edge) begin
               state_d      = ST_PLAY;
               preset_d     = 1'b1;
               lives_d      = 2'(START_LIVES);
               score_d      = '0;
               last_level_d = level_in;
            end
         end
         ST_PLAY: begin
            if (hit) begin
               state_d      = ST_DYING;
               timer_d      = TW'(DEATH_CYCLES - 1);
               lives_d      = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
               last_level_d = level_in;
            end else if (level_in != last_level_q) begin
               state_d      = ST_LEVELUP;
               timer_d      = TW'(LEVEL_CYCLES - 1);
               last_level_d = level_in;
               score_d      = sum_lvl[16] ? 16'hFFFF : sum_lvl[15:0];
            end else if (pause_sw) begin
               state_d = ST_PAUSED;
            end else begin
               pend_d = req;
               if (cool_q == '0 && req != '0) begin
                  cool_d = CW'(MOVE_GAP - 1);
                  if (req[0]) begin
                     mv_d[0]   = 1'b1;
                     pend_d[0] = 1'b0;
                  end else if (req[1]) begin
                     mv_d[1]   = 1'b1;
                     pend_d[1] = 1'b0;
                  end else if (req[2]) begin
                     mv_d[2]   = 1'b1;
                     pend_d[2] = 1'b0;
                  end else begin
                     mv_d[3]   = 1'b1;
                     pend_d[3] = 1'b0;
                     score_d   = sum_mv[16] ? 16'hFFFF : sum_mv[15:0];
                  end
               end
            end
         end
         ST_PAUSED: begin
            if (!pause_sw) state_d = ST_PLAY;
         end
         ST_DYING: begin
            if (timer_q == '0) begin
               if (lives_q == 2'd0) begin
                  state_d = ST_OVER;
               end else begin
                  state_d  = ST_PLAY;
                  preset_d = 1'b1;
               end
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         ST_LEVELUP: begin
            if (timer_q == '0) state_d = ST_PLAY;
            else               timer_d = timer_q - TW'(1);
         end
         ST_OVER: begin
            if (start_edge) state_d = ST_TITLE;
         end
         default: state_d = ST_TITLE;
      endcase
   end

   assign mv_up        = mv_q[0];
   assign mv_down      = mv_q[1];
   assign mv_left      = mv_q[2];
   assign mv_right     = mv_q[3];
   assign player_pause = (state_q != ST_PLAY);
   assign player_reset = preset_q;
   assign lives        = lives_q;
   assign score        = score_q;
   assign state        = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: randomized bench for game_ctrl.
// Reference model tracks game rules with absolute cycle stamps.
module tb_game_ctrl;

   localparam int G  = 2;
   localparam int DC = 4;
   localparam int LC = 4;
   localparam int SL = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        btn_up, btn_left, btn_right, btn_down;
   logic        btn_start, pause_sw, hit;
   logic [9:0]  level_in;
   logic        mv_up, mv_left, mv_right, mv_down;
   logic        player_pause, player_reset;
   logic [1:0]  lives;
   logic [15:0] score;
   logic [2:0]  state;

   always #5 clk = ~clk;

   game_ctrl #(
      .MOVE_GAP(G), .DEATH_CYCLES(DC),
      .LEVEL_CYCLES(LC), .START_LIVES(SL)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .btn_up(btn_up), .btn_left(btn_left),
      .btn_right(btn_right), .btn_down(btn_down),
      .btn_start(btn_start), .pause_sw(pause_sw),
      .hit(hit), .level_in(level_in),
      .mv_up(mv_up), .mv_left(mv_left),
      .mv_right(mv_right), .mv_down(mv_down),
      .player_pause(player_pause),
      .player_reset(player_reset),
      .lives(lives), .score(score), .state(state)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // model: 0 title,1 play,2 paused,3 dying,4 levelup,5 over
   int       m_state;
   bit [3:0] m_pend;
   int       m_last_issue;
   int       m_enter;
   int       m_lives;
   int       m_score;
   int       m_last_level;
   bit [3:0] m_prev;
   bit       m_sprev;
   bit [3:0] e_mv;
   bit       e_rst;
   int       k = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, k, got, exp);
      end
   endtask

   task automatic model_reset();
      m_state      = 0;
      m_pend       = '0;
      m_last_issue = -1000;
      m_enter      = 0;
      m_lives      = SL;
      m_score      = 0;
      m_last_level = 1;
      m_prev       = '0;
      m_sprev      = 1'b0;
      e_mv         = '0;
      e_rst        = 1'b0;
   endtask

   task automatic model_step();
      bit [3:0] now, edges;
      bit       sedge;
      if (!rst_n) begin
         model_reset();
         return;
      end
      now     = {btn_right, btn_left, btn_down, btn_up};
      edges   = now & ~m_prev;
      sedge   = btn_start && !m_sprev;
      m_prev  = now;
      m_sprev = btn_start;
      e_mv    = '0;
      e_rst   = 1'b0;
      case (m_state)
         0: if (sedge) begin
            m_state = 1; e_rst = 1'b1; m_lives = SL;
            m_score = 0; m_last_level = int'(level_in);
         end
         1: begin
            if (hit) begin
               m_state = 3; m_enter = k; m_pend = '0;
               m_lives = (m_lives > 0) ? m_lives - 1 : 0;
               m_last_level = int'(level_in);
            end else if (int'(level_in) != m_last_level) begin
               m_state = 4; m_enter = k; m_pend = '0;
               m_last_level = int'(level_in);
               m_score = (m_score + 100 > 65535) ? 65535 : m_score + 100;
            end else if (pause_sw) begin
               m_state = 2; m_pend = '0;
            end else begin
               m_pend = m_pend | edges;
               if (m_pend != 0 && k - m_last_issue >= G) begin
                  for (int i = 0; i < 4; i++) begin
                     if (m_pend[i]) begin
                        m_pend[i] = 1'b0;
                        e_mv[i] = 1'b1;
                        if (i == 3)
                           m_score = (m_score == 65535) ? 65535 : m_score + 1;
                        break;
                     end
                  end
                  m_last_issue = k;
               end
            end
         end
         2: if (!pause_sw) m_state = 1;
         3: if (k - m_enter == DC) begin
            if (m_lives == 0) m_state = 5;
            else begin m_state = 1; e_rst = 1'b1; end
         end
         4: if (k - m_enter == LC) m_state = 1;
         5: if (sedge) m_state = 0;
         default: m_state = 0;
      endcase
   endtask

   task automatic check_all();
      logic [3:0] mvv;
      mvv = {mv_right, mv_left, mv_down, mv_up};
      check("state", 32'(state), 32'(m_state));
      check("mv", 32'(mvv), 32'(e_mv));
      check("mv_onehot", 32'($countones(mvv) <= 1), 32'd1);
      check("pause", 32'(player_pause), 32'(m_state != 1));
      check("preset", 32'(player_reset), 32'(e_rst));
      check("lives", 32'(lives), 32'(m_lives));
      check("score", 32'(score), 32'(m_score));
   endtask

   task automatic step();
      @(posedge clk);
      k++;
      model_step();
      #1;
      check_all();
      @(negedge clk);
   endtask

   task automatic async_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      {btn_up, btn_left, btn_right, btn_down} = '0;
      btn_start = 0; pause_sw = 0; hit = 0; level_in = 10'd1;
      model_reset();
      #12;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      // start game
      btn_start = 1; step(); btn_start = 0; step();
      // simultaneous up/right, then held up
      btn_up = 1; btn_right = 1; step(); btn_right = 0;
      repeat (10) step();
      btn_up = 0; step();
      // three hits
      repeat (3) begin
         hit = 1; step(); hit = 0;
         repeat (DC + 2) step();
      end
      btn_start = 1; step(); btn_start = 0; step();
      btn_start = 1; step(); btn_start = 0; step();
      // level step with button edge during freeze
      level_in = 10'd2; step();
      btn_left = 1; repeat (LC + 2) step(); btn_left = 0;
      // pending left then pause
      btn_up = 1; btn_left = 1; step(); pause_sw = 1; step();
      btn_up = 0; btn_left = 0; repeat (3) step();
      pause_sw = 0; repeat (4) step();
      btn_left = 1; repeat (3) step(); btn_left = 0;
      // level wrap counts as change
      level_in = 10'h3FF; repeat (LC + 2) step();
      level_in = 10'h000; repeat (LC + 2) step();
      // reset mid-dying
      hit = 1; step(); hit = 0; step();
      async_reset();
      repeat (3) step();
      // randomized phase
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 3) == 0) btn_up    = ~btn_up;
         if ($urandom_range(0, 3) == 0) btn_down  = ~btn_down;
         if ($urandom_range(0, 3) == 0) btn_left  = ~btn_left;
         if ($urandom_range(0, 3) == 0) btn_right = ~btn_right;
         btn_start = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 11) == 0) pause_sw = ~pause_sw;
         hit = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 29) == 0) level_in = level_in + 10'd1;
         if ($urandom_range(0, 499) == 0) level_in = 10'($urandom);
         if ($urandom_range(0, 599) == 0) async_reset();
         else step();
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
